ws2812_rx: RTL and testbench
============================

# ws2812_rx

Single-wire WS2812 stream decoder: the receive end of the LED protocol our `ws2812` driver transmits. It samples the serial line, classifies each high pulse as a 0 or 1 bit by width, and assembles MSB-first 24-bit pixel words. It presents each word with its LED index and flags frame boundaries on the latch (reset) gap. Used for loopback verification of the driver on hardware and as the input stage of daisy-chain/bridge designs.

## Interface
- `NUM_LEDS`, 8: maximum pixels accepted per frame.
- `CLK_MHZ`, 12: system clock frequency in MHz.
- `T_THRESH`, ceil(CLK_MHZ*600/1000) (=8): a high pulse of at least this many cycles decodes as 1; a shorter one decodes as 0.
- `T_HIGH_MAX`, ceil(CLK_MHZ*2000/1000) (=24): a high pulse reaching this count is a bit error.
- `T_GAP`, CLK_MHZ*50 (=600): low cycles that constitute a latch gap.
- `T_GLITCH`, ceil(CLK_MHZ*100/1000) (=2): glitch width; used only with the filter enabled.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `din` input 1: serial line, asynchronous to `clk`.
- `rgb_data` output 24: last decoded word; the first received bit is bit 23.
- `led_index` output $clog2(NUM_LEDS): index of `rgb_data` within the frame; the first word is index 0.
- `rgb_valid` output 1: one-cycle strobe when `rgb_data`/`led_index` update.
- `frame_done` output 1: one-cycle strobe on a latch gap after at least one bit.
- `overflow` output 1: sticky; set when more than NUM_LEDS words arrive in a frame. Cleared on the next `frame_done`.
- `bit_error` output 1: one-cycle strobe on an over-long high pulse.

## Operation
- `din` passes through a 2-flop synchronizer, then a registered previous-value flop for edge detection.
- The pulse counter width is $clog2(T_GAP+1). It saturates and never wraps.
- States:
  - SYNC: entered on reset and after an error. Counts consecutive low cycles; any high clears the count. When the count reaches T_GAP, go to LOW with the bit and word counters cleared. No `frame_done` is issued from SYNC.
  - LOW: counts low cycles.
    - On a rising edge: clear the counter and go to HIGH.
    - When the count reaches T_GAP: pulse `frame_done` if any bit has arrived since the last gap. Discard any partial word (fewer than 24 bits), clear the bit and word counters, clear `overflow`, and stay in LOW.
  - HIGH: counts high cycles.
    - On a falling edge: shift in (count >= T_THRESH), then go to LOW with the counter cleared.
    - When the count reaches T_HIGH_MAX: pulse `bit_error`, discard the partial word, and go to SYNC.
- Word completion on the 24th bit:
  - If word count < NUM_LEDS: load `rgb_data` and `led_index` = word count, pulse `rgb_valid`, and increment the word count.
  - Otherwise: the word is dropped, `overflow` is set, and the word count saturates.
- `rgb_valid` and `frame_done` are never asserted in the same cycle. A gap needs at least T_GAP cycles after the last bit.

## Timing
- Reset values: `rgb_data`=0, `led_index`=0, `rgb_valid`=0, `frame_done`=0, `overflow`=0, `bit_error`=0; state SYNC; synchronizer flops 0.
- An asserted reset mid-frame aborts immediately. After release, the block waits a full T_GAP low before decoding.
- Latency:
  - `rgb_valid` rises 3 clk edges after the first edge that samples the 24th bit's falling edge low (2 synchronizer + 1 register).
  - `frame_done` asserts T_GAP+3 edges after `din` falls.
- Pulse widths are measured with ±1 cycle of uncertainty from asynchronous sampling. The thresholds leave margin for WS2812 tolerances at CLK_MHZ ≥ 12.
- Downstream must accept `rgb_valid` in a single cycle. There is no backpressure; words arrive no faster than every 24×T_period.

## Configuration
- `WS2812_RX_GLITCH_FILTER_EN` defined: a high pulse shorter than T_GLITCH is ignored. No bit is shifted, and the block returns to LOW with the low count restarting at 0.
- Undefined: every high pulse of one or more synchronized cycles decodes as a bit; short pulses decode as 0.

## Structure
- Package `ws2812_pkg`:
  - State encoding (SYNC/LOW/HIGH).
  - Constant functions computing timing counts from CLK_MHZ, shared with the transmitter.
  - The 24-bit pixel word width.
- Sub-module `ws2812_din_sync`: 2-flop synchronizer plus `rise`/`fall` edge pulses.

## Test plan
- Reset release, `din` low for 600 cycles, then one pixel 0xA5_3C_F0 (1 = 11 high/4 low, 0 = 5 high/10 low) → `rgb_valid` once, `rgb_data`=0xA53CF0, `led_index`=0; after 600 low cycles, `frame_done` once.
- 8 pixels 0x000001…0x000008 from the `ws2812` driver in loopback → 8 strobes, indices 0–7, data matches, `overflow`=0.
- 9 pixels with NUM_LEDS=8 → 8 strobes, `overflow`=1 after the 9th word, cleared in the `frame_done` cycle.
- 30-cycle high pulse mid-word → `bit_error` once; no `rgb_valid`; the next valid frame decodes only after 600 low cycles.
- 12 bits, then a 600-cycle gap → no `rgb_valid`, `frame_done` once; the following full pixel decodes with `led_index`=0.
- With WS2812_RX_GLITCH_FILTER_EN, a 1-cycle spike between bits → ignored and the word still decodes correctly; without the macro, the same stimulus shifts an extra 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812 shared package: state encoding, pixel width, timing helpers.
// Timing helpers are shared with the ws2812 transmitter.
package ws2812_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LOW,
    ST_HIGH
  } rx_state_t;

  function automatic int t_thresh(input int clk_mhz);
    return (clk_mhz * 600 + 999) / 1000;
  endfunction

  function automatic int t_high_max(input int clk_mhz);
    return (clk_mhz * 2000 + 999) / 1000;
  endfunction

  function automatic int t_gap(input int clk_mhz);
    return clk_mhz * 50;
  endfunction

  function automatic int t_glitch(input int clk_mhz);
    return (clk_mhz * 100 + 999) / 1000;
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx output bundle: decoded pixel words and frame status.
// master = decoder, slave = consumer.
interface ws2812_rx_if #(
  parameter int NUM_LEDS = 8
);
  import ws2812_pkg::*;

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic [PIX_W-1:0] rgb_data;
  logic [IW-1:0]    led_index;
  logic             rgb_valid;
  logic             frame_done;
  logic             overflow;
  logic             bit_error;

  modport master (
    output rgb_data,
    output led_index,
    output rgb_valid,
    output frame_done,
    output overflow,
    output bit_error
  );

  modport slave (
    input rgb_data,
    input led_index,
    input rgb_valid,
    input frame_done,
    input overflow,
    input bit_error
  );

endinterface

// File: rtl/ws2812_din_sync.sv
// ws2812_din_sync: 2-flop synchronizer for din plus
// registered previous value giving rise/fall pulses.
module ws2812_din_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire stream decoder, 24-bit MSB-first words.
// Optional glitch filter: define WS2812_RX_GLITCH_FILTER_EN.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_MHZ    = 12,
  parameter int T_THRESH   = t_thresh(CLK_MHZ),
  parameter int T_HIGH_MAX = t_high_max(CLK_MHZ),
  parameter int T_GAP      = t_gap(CLK_MHZ),
  parameter int T_GLITCH   = t_glitch(CLK_MHZ)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  ws2812_rx_if.master rx
);

  localparam int CW  = $clog2(T_GAP + 1);
  localparam int WCW = $clog2(NUM_LEDS + 1);
  localparam int IW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] GAP  = CW'(T_GAP);
  localparam logic [CW-1:0] GAP1 = CW'(T_GAP - 1);
  localparam logic [CW-1:0] THR  = CW'(T_THRESH);
  localparam logic [CW-1:0] HMAX = CW'(T_HIGH_MAX);
  localparam logic [CW-1:0] GLT  = CW'(T_GLITCH);
  localparam logic [WCW-1:0] NL  = WCW'(NUM_LEDS);

`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic level;
  logic rise;
  logic fall;

  ws2812_din_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [4:0]       bit_cnt;
  logic [WCW-1:0]   word_cnt;
  logic             seen;
  logic [PIX_W-2:0] shreg;

  logic [PIX_W-1:0] rgb_data_q;
  logic [IW-1:0]    led_index_q;
  logic             rgb_valid_q;
  logic             frame_done_q;
  logic             overflow_q;
  logic             bit_error_q;

  logic             bit_v;
  logic             short_pulse;
  logic [PIX_W-1:0] word;

  assign bit_v       = (cnt >= THR);
  assign short_pulse = GLITCH_EN && (cnt < GLT);
  assign word        = {shreg, bit_v};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_SYNC;
      cnt          <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      seen         <= 1'b0;
      shreg        <= '0;
      rgb_data_q   <= '0;
      led_index_q  <= '0;
      rgb_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      bit_error_q  <= 1'b0;
    end else begin
      rgb_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      bit_error_q  <= 1'b0;
      unique case (state)
        ST_SYNC: begin
          if (level) begin
            cnt <= '0;
          end else if (cnt >= GAP1) begin
            state    <= ST_LOW;
            cnt      <= GAP;
            bit_cnt  <= '0;
            word_cnt <= '0;
            seen     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == GAP1) begin
            cnt          <= GAP;
            frame_done_q <= seen;
            seen         <= 1'b0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            overflow_q   <= 1'b0;
          end else if (cnt < GAP) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
            cnt   <= '0;
            if (!short_pulse) begin
              seen  <= 1'b1;
              shreg <= word[PIX_W-2:0];
              if (bit_cnt == 5'(PIX_W - 1)) begin
                bit_cnt <= '0;
                if (word_cnt < NL) begin
                  rgb_data_q  <= word;
                  led_index_q <= word_cnt[IW-1:0];
                  rgb_valid_q <= 1'b1;
                  word_cnt    <= word_cnt + 1'b1;
                end else begin
                  overflow_q <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else if (cnt >= HMAX) begin
            // over-long high: resync before trusting the line again
            bit_error_q <= 1'b1;
            bit_cnt     <= '0;
            state       <= ST_SYNC;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  assign rx.rgb_data   = rgb_data_q;
  assign rx.led_index  = led_index_q;
  assign rx.rgb_valid  = rgb_valid_q;
  assign rx.frame_done = frame_done_q;
  assign rx.overflow   = overflow_q;
  assign rx.bit_error  = bit_error_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed stimulus with an event scoreboard for ws2812_rx.
// Optional glitch filter: define WS2812_RX_GLITCH_FILTER_EN.
module tb_ws2812_rx;

  localparam int EV_VALID = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int          kind;
    logic [23:0] data;
    logic [2:0]  idx;
  } ev_t;

  logic clk;
  logic rst_n;
  logic din;

  int total;
  int bad;
  ev_t exp_q[$];

  ws2812_rx_if #(.NUM_LEDS(8)) rx_if ();

  ws2812_rx dut (
    .clk   (clk),
    .reset (rst_n),
    .din   (din),
    .rx    (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [23:0] d,
                      input logic [2:0] i);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    cyc(b ? 11 : 5);
    din = 1'b0;
    cyc(b ? 4 : 10);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic gap();
    din = 1'b0;
    cyc(650);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.rgb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {8'h0, rx_if.rgb_data}, 32'hdead);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("valid_kind", 32'(EV_VALID), 32'(e.kind));
          chk("rgb_data", {8'h0, rx_if.rgb_data}, {8'h0, e.data});
          chk("led_index", {29'h0, rx_if.led_index}, {29'h0, e.idx});
        end
      end
      if (rx_if.frame_done) begin
        chk("overflow_at_frame", {31'h0, rx_if.overflow}, 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'h1, 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("frame_kind", 32'(EV_FRAME), 32'(e.kind));
        end
      end
      if (rx_if.bit_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 32'h1, 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("err_kind", 32'(EV_ERR), 32'(e.kind));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    logic [23:0] wexp;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    din   = 1'b0;
    cyc(5);
    chk("rst_rgb_data", {8'h0, rx_if.rgb_data}, 32'h0);
    chk("rst_led_index", {29'h0, rx_if.led_index}, 32'h0);
    chk("rst_rgb_valid", {31'h0, rx_if.rgb_valid}, 32'h0);
    chk("rst_frame_done", {31'h0, rx_if.frame_done}, 32'h0);
    chk("rst_overflow", {31'h0, rx_if.overflow}, 32'h0);
    chk("rst_bit_error", {31'h0, rx_if.bit_error}, 32'h0);
    rst_n = 1'b1;
    cyc(620);

    push(EV_VALID, 24'hA53CF0, 3'd0);
    send_bits(24'hA53CF0, 24);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();

    for (int i = 1; i <= 8; i++) begin
      push(EV_VALID, 24'(i), 3'(i - 1));
      send_bits(24'(i), 24);
    end
    chk("overflow_8", {31'h0, rx_if.overflow}, 32'h0);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();

    for (int i = 1; i <= 8; i++) begin
      push(EV_VALID, 24'(i + 16), 3'(i - 1));
      send_bits(24'(i + 16), 24);
    end
    chk("overflow_pre9", {31'h0, rx_if.overflow}, 32'h0);
    send_bits(24'h000019, 24);
    chk("overflow_9", {31'h0, rx_if.overflow}, 32'h1);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();
    chk("overflow_clr", {31'h0, rx_if.overflow}, 32'h0);

    send_bits(24'hF0F0F0, 5);
    push(EV_ERR, 24'h0, 3'd0);
    din = 1'b1;
    cyc(30);
    din = 1'b0;
    cyc(300);
    send_bits(24'h777777, 24);
    cyc(620);
    push(EV_VALID, 24'h123456, 3'd0);
    send_bits(24'h123456, 24);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();

    send_bits(24'hABCDEF, 12);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();
    push(EV_VALID, 24'h5A5A5A, 3'd0);
    send_bits(24'h5A5A5A, 24);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();

    w = 24'hC3A596;
`ifdef WS2812_RX_GLITCH_FILTER_EN
    wexp = w;
`else
    wexp = {w[23:12], 1'b0, w[11:1]};
`endif
    push(EV_VALID, wexp, 3'd0);
    send_bits(w, 12);
    din = 1'b1;
    cyc(1);
    din = 1'b0;
    cyc(5);
    for (int i = 11; i >= 0; i--) send_bit(w[i]);
    push(EV_FRAME, 24'h0, 3'd0);
    gap();

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc(1);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
